k_rpack_t1: RTL and testbench

- Single-clock consumer for the read side of the codebase's 2-deep sync FIFO. It drives the rrdy/rget/rdata interface.
- It packs pack_n consecutive data_size-bit words into one wide word, first word in the LSB lane.
- It presents the wide word on a valid/ready output port and supports a flush request that emits a partial word.

---
 rtl/k_fifo_pkg_t1.sv | 18 +
 rtl/k_lane_wr_t1.sv | 18 +
 rtl/k_rpack_t1.sv | 100 ++++++++++
 tb/tb_k_rpack_t1.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/k_fifo_pkg_t1.sv
// Shared definitions for the sync-FIFO read-side consumers: state encoding and
// the packed-output count width.
package k_fifo_pkg_t1;

  localparam logic FILL = 1'b0;
  localparam logic HOLD = 1'b1;

  typedef enum logic {
    StFill = FILL,
    StHold = HOLD
  } pack_state_e;

  // out_cnt must hold the value pack_n itself.
  function automatic int unsigned out_cnt_w(input int unsigned pack_n);
    return $clog2(pack_n + 1);
  endfunction

endpackage

// File: rtl/k_lane_wr_t1.sv
// Lane-write demux: turns a lane index plus enable into a one-hot write strobe.
module k_lane_wr_t1 #(
  parameter int unsigned lanes = 4,
  parameter int unsigned sel_w = 2
) (
  input  logic [sel_w-1:0] sel,
  input  logic             en,
  output logic [lanes-1:0] we
);

  always_comb begin
    we = '0;
    for (int i = 0; i < lanes; i++) begin
      we[i] = en && (sel == sel_w'(i));
    end
  end

endmodule

// File: rtl/k_rpack_t1.sv
// FIFO read-side packer: gathers pack_n words (first word in lane 0) into one
// wide word and presents it on a valid/ready port; flush emits a partial word.
module k_rpack_t1
  import k_fifo_pkg_t1::*;
#(
  parameter int unsigned data_size = 8,
  parameter int unsigned pack_n    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [data_size-1:0]              rdata,
  input  logic                              rrdy,
  output logic                              rget,
  input  logic                              flush,
  output logic [data_size*pack_n-1:0]       out_data,
  output logic [out_cnt_w(pack_n)-1:0]      out_cnt,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam int unsigned CntW    = $clog2(pack_n);
  localparam int unsigned OutCntW = out_cnt_w(pack_n);
  localparam int unsigned DataW   = data_size * pack_n;
  localparam logic [CntW-1:0] LastLane = CntW'(pack_n - 1);

  pack_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataW-1:0]     data_q, data_d;
  logic [OutCntW-1:0]   out_cnt_q, out_cnt_d;
  logic [pack_n-1:0]    lane_we;

  assign rget = rrdy && (state_q == StFill) && !rst;

  k_lane_wr_t1 #(
    .lanes (pack_n),
    .sel_w (CntW)
  ) u_lane_wr (
    .sel (cnt_q),
    .en  (rget),
    .we  (lane_we)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    out_cnt_d = out_cnt_q;
    for (int i = 0; i < pack_n; i++) begin
      if (lane_we[i]) begin
        data_d[i*data_size +: data_size] = rdata;
      end
    end
    unique case (state_q)
      StFill: begin
        if (rget) begin
          // A flush on the capture edge still includes the captured word.
          if (cnt_q == LastLane || flush) begin
            state_d   = StHold;
            out_cnt_d = OutCntW'(cnt_q) + OutCntW'(1);
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (flush && cnt_q != '0) begin
          state_d   = StHold;
          out_cnt_d = OutCntW'(cnt_q);
          cnt_d     = '0;
        end
      end
      StHold: begin
        if (out_ready) begin
          // Clearing here keeps unused lanes of the next partial word at zero.
          state_d   = StFill;
          data_d    = '0;
          out_cnt_d = '0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFill;
      cnt_q     <= '0;
      data_q    <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign out_valid = (state_q == StHold);
  assign out_data  = out_valid ? data_q : '0;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_k_rpack_t1.sv
// Bench for k_rpack_t1: queue-based reference model checked every cycle, directed
// literal checks, and a randomised pack_n=2 scoreboard run.
module tb_k_rpack_t1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rdata = '0;
  logic        rrdy = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        rget, out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;

  logic [7:0]  rdata2 = '0;
  logic        rrdy2 = 1'b0, flush2 = 1'b0, out_ready2 = 1'b0;
  logic        rget2, out_valid2;
  logic [15:0] out_data2;
  logic [1:0]  out_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  k_rpack_t1 #(.data_size(8), .pack_n(4)) dut (
    .clk(clk), .rst(rst), .rdata(rdata), .rrdy(rrdy), .rget(rget), .flush(flush),
    .out_data(out_data), .out_cnt(out_cnt), .out_valid(out_valid), .out_ready(out_ready)
  );

  k_rpack_t1 #(.data_size(8), .pack_n(2)) dut2 (
    .clk(clk), .rst(rst), .rdata(rdata2), .rrdy(rrdy2), .rget(rget2), .flush(flush2),
    .out_data(out_data2), .out_cnt(out_cnt2), .out_valid(out_valid2),
    .out_ready(out_ready2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: captured words queue up; a word is emitted once pack_n
  // words are queued or flush sees a non-empty queue; it is held until taken.
  logic [7:0]  pend[$];
  bit          m_hold = 1'b0;
  logic [31:0] m_data = '0;
  logic [2:0]  m_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      m_hold = 1'b0;
      m_data = '0;
      m_cnt  = '0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_data = '0;
        m_cnt  = '0;
      end
    end else begin
      if (rrdy) pend.push_back(rdata);
      if (pend.size() == 4 || (flush && pend.size() > 0)) begin
        m_data = '0;
        foreach (pend[i]) m_data = m_data | (32'(pend[i]) << (8 * i));
        m_cnt  = 3'(pend.size());
        m_hold = 1'b1;
        pend.delete();
      end
    end
  end

  // Per-cycle comparison plus event counters for the directed checks.
  int vcnt = 0, gcnt = 0, hs = 0;
  logic [31:0] last_word = '0;
  logic [2:0]  last_cnt = '0;

  always @(negedge clk) begin
    chk("model_rget", rget, rrdy && !m_hold && !rst);
    chk("model_valid", out_valid, m_hold);
    chk("model_data", out_data, m_data);
    chk("model_cnt", out_cnt, m_cnt);
    if (out_valid) vcnt++;
    if (rget) gcnt++;
    if (out_valid && out_ready) begin
      hs++;
      last_word = out_data;
      last_cnt  = out_cnt;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one word like the FIFO does; rrdy drops for a cycle after each get.
  task automatic push(input logic [7:0] d, input logic fl);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    rrdy = 1'b1;
    rdata = d;
    flush = fl;
    while (!got && n < 40) begin
      @(negedge clk);
      got = rget;
      n++;
      cycle();
    end
    rrdy = 1'b0;
    flush = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=no_rget required=rget");
    end
    cycle();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  int v0, g0, h0, seq, k, cyc;
  bit took;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, 32'h0);
    chk("reset_cnt", out_cnt, 3'd0);
    chk("reset_valid2", out_valid2, 1'b0);
    rrdy = 1'b1;
    #1 chk("reset_rget", rget, 1'b0);
    rrdy = 1'b0;
    rst = 1'b0;
    cycle();

    // 1: four words, downstream always ready
    out_ready = 1'b1;
    v0 = vcnt; g0 = gcnt; h0 = hs;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
    repeat (2) cycle();
    chk("t1_data", last_word, 32'h44332211);
    chk("t1_cnt", last_cnt, 3'd4);
    chk("t1_valid_cycles", vcnt - v0, 1);
    chk("t1_rget_pulses", gcnt - g0, 4);
    chk("t1_handshakes", hs - h0, 1);

    // 2: two words then a standalone flush; next word restarts at lane 0
    push(8'hAA, 1'b0); push(8'hBB, 1'b0);
    pulse_flush();
    repeat (2) cycle();
    chk("t2_data", last_word, 32'h0000BBAA);
    chk("t2_cnt", last_cnt, 3'd2);
    push(8'hCC, 1'b0);
    pulse_flush();
    repeat (2) cycle();
    chk("t2_lane0", last_word, 32'h000000CC);
    chk("t2_lane0_cnt", last_cnt, 3'd1);

    // 3: backpressure for 10 cycles with rrdy high
    out_ready = 1'b0;
    push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0); push(8'hA4, 1'b0);
    rrdy = 1'b1;
    rdata = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_rget", rget, 1'b0);
      chk("t3_hold_data", out_data, 32'hA4A3A2A1);
      chk("t3_hold_valid", out_valid, 1'b1);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    @(negedge clk);
    chk("t3_rget_after_hs", rget, 1'b1);
    cycle();
    rrdy = 1'b0;
    pulse_flush();
    repeat (2) cycle();
    chk("t3_next_word", last_word, 32'h00000055);

    // 4: flush on the third capture edge; then flush with nothing captured
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b1);
    repeat (2) cycle();
    chk("t4_data", last_word, 32'h00030201);
    chk("t4_cnt", last_cnt, 3'd3);
    v0 = vcnt; h0 = hs;
    flush = 1'b1;
    repeat (3) cycle();
    flush = 1'b0;
    cycle();
    chk("t4_empty_flush_valid", vcnt - v0, 0);
    chk("t4_empty_flush_hs", hs - h0, 0);

    // 5: asynchronous reset mid-cycle with a partial word in progress
    push(8'hE1, 1'b0); push(8'hE2, 1'b0); push(8'hE3, 1'b0);
    rrdy = 1'b1;
    rdata = 8'h77;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_rget", rget, 1'b0);
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_data", out_data, 32'h0);
    cycle();
    rrdy = 1'b0;
    rst = 1'b0;
    cycle();
    push(8'h5A, 1'b0); push(8'h6B, 1'b0);
    pulse_flush();
    repeat (2) cycle();
    chk("t5_no_stale", last_word, 32'h00006B5A);
    chk("t5_no_stale_cnt", last_cnt, 3'd2);
    push(8'h10, 1'b0); push(8'h20, 1'b0); push(8'h30, 1'b0); push(8'h40, 1'b0);
    repeat (2) cycle();
    chk("t5_full", last_word, 32'h40302010);

    // 6: pack_n=2, random rrdy/out_ready, sequential word source
    seq = 0; k = 0; cyc = 0;
    while (k < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (rget2 && !rrdy2) chk("t6_rget_without_rrdy", rget2, 1'b0);
      else checks++;
      took = rget2;
      if (out_valid2 && out_ready2) begin
        chk("t6_word", out_data2, {8'(k + 1), 8'(k)});
        chk("t6_cnt", out_cnt2, 2'd2);
        k += 2;
      end
      cycle();
      if (took) seq++;
      rrdy2 = took ? 1'b0 : 1'($urandom_range(0, 1));
      rdata2 = 8'(seq);
      out_ready2 = 1'($urandom_range(0, 1));
    end
    if (k < 1000) begin
      checks++;
      errors++;
      $display("FAIL t6_timeout actual=%0d required=1000", k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
